// File: rtl/sd_spi_pkg.sv
// Shared types and constants for the SD-card SPI-mode responder.
// CRC helpers are only referenced when SD_SPI_CRC_EN is defined.
package sd_spi_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CMD,
        S_NCR,
        S_RESP,
        S_FETCH,
        S_TOKEN,
        S_DATA,
        S_CRC
    } state_t;

    localparam logic [5:0] CMD_GO_IDLE     = 6'd0;
    localparam logic [5:0] CMD_SEND_IF     = 6'd8;
    localparam logic [5:0] CMD_READ_SINGLE = 6'd17;
    localparam logic [5:0] CMD_APP_OP      = 6'd41;
    localparam logic [5:0] CMD_APP         = 6'd55;
    localparam logic [5:0] CMD_READ_OCR    = 6'd58;

    localparam logic [7:0] R1_IDLE    = 8'h01;
    localparam logic [7:0] R1_ILLEGAL = 8'h04;
    localparam logic [7:0] R1_CRC_ERR = 8'h08;

    localparam logic [31:0] OCR       = 32'hC0FF_8000;
    localparam logic [7:0]  TOKEN     = 8'hFE;
    localparam logic [7:0]  IDLE_BYTE = 8'hFF;
    localparam int          BLOCK_SIZE = 512;
    localparam logic [8:0]  LAST_IDX  = 9'(BLOCK_SIZE - 1);

    function automatic logic [6:0] crc7_byte(input logic [6:0] crc, input logic [7:0] d);
        logic [6:0] c;
        logic       fb;
        c = crc;
        for (int i = 7; i >= 0; i--) begin
            fb = c[6] ^ d[i];
            c  = {c[5:0], 1'b0};
            if (fb) c = c ^ 7'h09;
        end
        return c;
    endfunction

    function automatic logic [15:0] crc16_byte(input logic [15:0] crc, input logic [7:0] d);
        logic [15:0] c;
        logic        fb;
        c = crc;
        for (int i = 7; i >= 0; i--) begin
            fb = c[15] ^ d[i];
            c  = {c[14:0], 1'b0};
            if (fb) c = c ^ 16'h1021;
        end
        return c;
    endfunction

endpackage

// File: rtl/sd_spi_shifter.sv
// SPI mode-0 byte engine: synchronizes SCK/MOSI/nCS onto clk, shifts rx on
// SCK rise and tx on SCK fall, and strobes byte-valid / tx-load events.
module sd_spi_shifter
    import sd_spi_pkg::*;
(
    input  logic       clk,
    input  logic       n_rst,
    input  logic       sck,
    input  logic       mosi,
    input  logic       n_cs,
    input  logic [7:0] tx_byte,
    output logic       miso,
    output logic       miso_oe,
    output logic [7:0] rx_byte,
    output logic       rx_valid,
    output logic       tx_load,
    output logic       desel
);
    logic       sck_p0, sck_p1, sck_p2;
    logic       mosi_p0, mosi_p1;
    logic       cs_p0, cs_p1, cs_p2;
    logic [7:0] rx_sr, tx_sr;
    logic [2:0] bit_cnt;
    logic       load_pend;
    logic       sck_rise, sck_fall, cs_fall;

    assign sck_rise = sck_p1 & ~sck_p2;
    assign sck_fall = ~sck_p1 & sck_p2;
    assign cs_fall  = ~cs_p1 & cs_p2;
    assign desel    = cs_p1 & ~cs_p2;
    assign miso_oe  = ~cs_p1;
    assign miso     = cs_p1 ? 1'b1 : tx_sr[7];

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            sck_p0    <= 1'b0;
            sck_p1    <= 1'b0;
            sck_p2    <= 1'b0;
            mosi_p0   <= 1'b0;
            mosi_p1   <= 1'b0;
            cs_p0     <= 1'b1;
            cs_p1     <= 1'b1;
            cs_p2     <= 1'b1;
            rx_sr     <= 8'h00;
            tx_sr     <= IDLE_BYTE;
            rx_byte   <= 8'h00;
            rx_valid  <= 1'b0;
            tx_load   <= 1'b0;
            bit_cnt   <= 3'd0;
            load_pend <= 1'b0;
        end else begin
            sck_p0   <= sck;
            sck_p1   <= sck_p0;
            sck_p2   <= sck_p1;
            mosi_p0  <= mosi;
            mosi_p1  <= mosi_p0;
            cs_p0    <= n_cs;
            cs_p1    <= cs_p0;
            cs_p2    <= cs_p1;
            rx_valid <= 1'b0;
            tx_load  <= 1'b0;
            // deselect discards any partial byte; select presents the MSB before the first rise
            if (cs_p1) begin
                bit_cnt   <= 3'd0;
                load_pend <= 1'b0;
                tx_sr     <= IDLE_BYTE;
            end else if (cs_fall) begin
                tx_sr     <= tx_byte;
                tx_load   <= 1'b1;
                bit_cnt   <= 3'd0;
                load_pend <= 1'b0;
            end else begin
                if (sck_rise) begin
                    rx_sr   <= {rx_sr[6:0], mosi_p1};
                    bit_cnt <= bit_cnt + 3'd1;
                    if (bit_cnt == 3'd7) begin
                        rx_byte   <= {rx_sr[6:0], mosi_p1};
                        rx_valid  <= 1'b1;
                        load_pend <= 1'b1;
                    end
                end
                if (sck_fall) begin
                    if (load_pend) begin
                        tx_sr     <= tx_byte;
                        tx_load   <= 1'b1;
                        load_pend <= 1'b0;
                    end else begin
                        tx_sr <= {tx_sr[6:0], 1'b1};
                    end
                end
            end
        end
    end

endmodule

// File: rtl/sd_spi_card.sv
// SD-card SPI-mode responder: frames commands, answers CMD0/8/55/ACMD41/58/17
// and streams 512-byte blocks from the byte-read port. Option macro: SD_SPI_CRC_EN.
module sd_spi_card
    import sd_spi_pkg::*;
(
    input  logic        clk,
    input  logic        n_rst,
    input  logic        sck,
    input  logic        mosi,
    input  logic        n_cs,
    output logic        miso,
    output logic        miso_oe,
    output logic        rd_req,
    output logic [31:0] rd_lba,
    output logic [8:0]  rd_idx,
    input  logic [7:0]  rd_data,
    input  logic        rd_ack
);
    state_t      state, state_nx;
    logic [7:0]  tx_next, tx_nx, rx_byte;
    logic        rx_valid, tx_load, desel;
    logic [5:0]  cmd_idx;
    logic [31:0] arg;
    logic [2:0]  byte_cnt;
    logic [7:0]  r1;
    logic [31:0] resp_tail;
    logic [2:0]  resp_left;
    logic        is_read, idle_st, app;
    logic [7:0]  data_buf;
    logic        data_ok;
    logic [8:0]  data_cnt;
    logic        crc_cnt;
    logic [7:0]  crc_hi, crc_lo;
    logic [7:0]  dec_r1;
    logic [31:0] dec_tail;
    logic        dec_long, dec_read, dec_idle, dec_app, crc_bad;

`ifdef SD_SPI_CRC_EN
    logic [6:0]  crc7;
    logic [15:0] crc16;
    assign crc_bad = (crc7 != rx_byte[7:1]);
    assign crc_hi  = crc16[15:8];
    assign crc_lo  = crc16[7:0];
`else
    assign crc_bad = 1'b0;
    assign crc_hi  = IDLE_BYTE;
    assign crc_lo  = IDLE_BYTE;
`endif

    sd_spi_shifter u_shifter (
        .clk      (clk),
        .n_rst    (n_rst),
        .sck      (sck),
        .mosi     (mosi),
        .n_cs     (n_cs),
        .tx_byte  (tx_next),
        .miso     (miso),
        .miso_oe  (miso_oe),
        .rx_byte  (rx_byte),
        .rx_valid (rx_valid),
        .tx_load  (tx_load),
        .desel    (desel)
    );

    // command decode, evaluated while the final (CRC) command byte is valid
    always_comb begin
        dec_r1   = {7'd0, idle_st};
        dec_tail = 32'hFFFF_FFFF;
        dec_long = 1'b0;
        dec_read = 1'b0;
        dec_idle = idle_st;
        dec_app  = 1'b0;
        if (crc_bad) begin
            dec_r1  = R1_CRC_ERR | {7'd0, idle_st};
            dec_app = app;
        end else if (app && cmd_idx == CMD_APP_OP) begin
            dec_idle = 1'b0;
            dec_r1   = 8'h00;
        end else begin
            case (cmd_idx)
                CMD_GO_IDLE: begin
                    dec_idle = 1'b1;
                    dec_r1   = R1_IDLE;
                end
                CMD_SEND_IF: begin
                    dec_long = 1'b1;
                    dec_tail = {16'h0000, 8'h01, arg[7:0]};
                end
                CMD_APP:      dec_app = 1'b1;
                CMD_READ_OCR: begin
                    dec_long = 1'b1;
                    dec_tail = OCR;
                end
                CMD_READ_SINGLE: begin
                    if (idle_st) dec_r1 = R1_IDLE | R1_ILLEGAL;
                    else         dec_read = 1'b1;
                end
                default: dec_r1 = {7'd0, idle_st} | R1_ILLEGAL;
            endcase
        end
    end

    // byte-slot FSM: at each received byte, choose the byte for the next slot
    always_comb begin
        state_nx = state;
        tx_nx    = tx_next;
        if (rx_valid) begin
            case (state)
                S_IDLE:  if (rx_byte[7:6] == 2'b01) state_nx = S_CMD;
                S_CMD:   if (byte_cnt == 3'd4) state_nx = S_NCR;
                S_NCR: begin
                    state_nx = S_RESP;
                    tx_nx    = r1;
                end
                S_RESP: begin
                    if (resp_left != 3'd0) begin
                        tx_nx = resp_tail[31:24];
                    end else begin
                        tx_nx    = IDLE_BYTE;
                        state_nx = is_read ? S_FETCH : S_IDLE;
                    end
                end
                S_FETCH: if (data_ok) begin
                    state_nx = S_TOKEN;
                    tx_nx    = TOKEN;
                end
                S_TOKEN: begin
                    state_nx = S_DATA;
                    tx_nx    = data_buf;
                end
                S_DATA: begin
                    if (data_cnt == LAST_IDX) begin
                        state_nx = S_CRC;
                        tx_nx    = crc_hi;
                    end else begin
                        tx_nx = data_buf;
                    end
                end
                S_CRC: begin
                    if (crc_cnt) begin
                        state_nx = S_IDLE;
                        tx_nx    = IDLE_BYTE;
                    end else begin
                        tx_nx = crc_lo;
                    end
                end
                default: state_nx = S_IDLE;
            endcase
        end
        if (desel) begin
            state_nx = S_IDLE;
            tx_nx    = IDLE_BYTE;
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) state <= S_IDLE;
        else        state <= state_nx;
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            tx_next   <= IDLE_BYTE;
            cmd_idx   <= 6'd0;
            arg       <= 32'd0;
            byte_cnt  <= 3'd0;
            r1        <= 8'h00;
            resp_tail <= 32'd0;
            resp_left <= 3'd0;
            is_read   <= 1'b0;
            idle_st   <= 1'b1;
            app       <= 1'b0;
            data_buf  <= 8'h00;
            data_ok   <= 1'b0;
            data_cnt  <= 9'd0;
            crc_cnt   <= 1'b0;
            rd_req    <= 1'b0;
            rd_lba    <= 32'd0;
            rd_idx    <= 9'd0;
`ifdef SD_SPI_CRC_EN
            crc7      <= 7'd0;
            crc16     <= 16'd0;
`endif
        end else begin
            tx_next <= tx_nx;
            if (rx_valid) begin
                case (state)
                    S_IDLE: if (rx_byte[7:6] == 2'b01) begin
                        cmd_idx  <= rx_byte[5:0];
                        byte_cnt <= 3'd0;
`ifdef SD_SPI_CRC_EN
                        crc7     <= crc7_byte(7'd0, rx_byte);
`endif
                    end
                    S_CMD: begin
                        if (byte_cnt == 3'd4) begin
                            r1        <= dec_r1;
                            resp_tail <= dec_tail;
                            resp_left <= dec_long ? 3'd4 : 3'd0;
                            is_read   <= dec_read;
                            idle_st   <= dec_idle;
                            app       <= dec_app;
                        end else begin
                            arg      <= {arg[23:0], rx_byte};
                            byte_cnt <= byte_cnt + 3'd1;
`ifdef SD_SPI_CRC_EN
                            crc7     <= crc7_byte(crc7, rx_byte);
`endif
                        end
                    end
                    S_RESP: if (resp_left != 3'd0) begin
                        resp_tail <= {resp_tail[23:0], IDLE_BYTE};
                        resp_left <= resp_left - 3'd1;
                    end
                    S_TOKEN: begin
                        data_cnt <= 9'd0;
`ifdef SD_SPI_CRC_EN
                        crc16    <= crc16_byte(16'd0, data_buf);
`endif
                    end
                    S_DATA: begin
                        if (data_cnt != LAST_IDX) begin
                            data_cnt <= data_cnt + 9'd1;
`ifdef SD_SPI_CRC_EN
                            crc16    <= crc16_byte(crc16, data_buf);
`endif
                        end else begin
                            crc_cnt <= 1'b0;
                        end
                    end
                    S_CRC:   crc_cnt <= 1'b1;
                    default: ;
                endcase
            end

            if (rd_req && rd_ack) begin
                rd_req   <= 1'b0;
                data_buf <= rd_data;
                data_ok  <= 1'b1;
            end
            // prefetch: the next byte is requested as soon as the current one enters the tx reg
            if (state == S_RESP && state_nx == S_FETCH) begin
                rd_req  <= 1'b1;
                rd_lba  <= arg;
                rd_idx  <= 9'd0;
                data_ok <= 1'b0;
            end else if (state == S_DATA && tx_load && rd_idx != LAST_IDX) begin
                rd_req <= 1'b1;
                rd_idx <= rd_idx + 9'd1;
            end
            if (desel) rd_req <= 1'b0;
        end
    end

endmodule

// File: tb/tb_sd_spi_card.sv
// Directed bench for sd_spi_card: SPI master driver, byte scoreboard queue and
// a read-port memory model returning idx^0x5A after a 10-clk acknowledge.
module tb_sd_spi_card;

    logic        clk = 1'b0;
    logic        n_rst, sck, mosi, n_cs;
    logic        miso, miso_oe, rd_req, rd_ack;
    logic [31:0] rd_lba;
    logic [8:0]  rd_idx;
    logic [7:0]  rd_data;

    int          checks = 0;
    int          errors = 0;
    logic [7:0]  exp_q[$];
    logic [7:0]  b;
    logic [15:0] dcrc;
    logic        found;

    always #5 clk = ~clk;

    sd_spi_card dut (
        .clk     (clk),
        .n_rst   (n_rst),
        .sck     (sck),
        .mosi    (mosi),
        .n_cs    (n_cs),
        .miso    (miso),
        .miso_oe (miso_oe),
        .rd_req  (rd_req),
        .rd_lba  (rd_lba),
        .rd_idx  (rd_idx),
        .rd_data (rd_data),
        .rd_ack  (rd_ack)
    );

    function automatic logic [7:0] cmd_crc(input logic [5:0] idx, input logic [31:0] a);
        logic [39:0] m;
        logic [6:0]  c;
        logic        fb;
        m = {2'b01, idx, a};
        c = 7'd0;
        for (int i = 39; i >= 0; i--) begin
            fb = c[6] ^ m[i];
            c  = {c[5:0], 1'b0};
            if (fb) c = c ^ 7'h09;
        end
        return {c, 1'b1};
    endfunction

    function automatic logic [15:0] crc16_upd(input logic [15:0] c_in, input logic [7:0] d);
        logic [15:0] c;
        logic        fb;
        c = c_in;
        for (int i = 7; i >= 0; i--) begin
            fb = c[15] ^ d[i];
            c  = {c[14:0], 1'b0};
            if (fb) c = c ^ 16'h1021;
        end
        return c;
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic xfer(input logic [7:0] dout, output logic [7:0] din);
        for (int i = 7; i >= 0; i--) begin
            mosi = dout[i];
            repeat (4) @(negedge clk);
            sck     = 1'b1;
            din[i]  = miso;
            repeat (4) @(negedge clk);
            sck = 1'b0;
        end
    endtask

    task automatic xchk(input logic [7:0] dout, input string tag);
        logic [7:0] got, exp;
        xfer(dout, got);
        exp = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hxx;
        check(tag, {24'd0, got}, {24'd0, exp});
    endtask

    task automatic command(input logic [5:0] idx, input logic [31:0] a, input logic [7:0] crc,
                           input int nresp, input logic [39:0] resp, input string tag);
        logic [47:0] frame;
        frame = {2'b01, idx, a, crc};
        for (int i = 0; i < 7; i++) exp_q.push_back(8'hFF);
        for (int i = 0; i < nresp; i++) exp_q.push_back(resp[39-8*i -: 8]);
        for (int i = 0; i < 6; i++) xchk(frame[47-8*i -: 8], tag);
        for (int i = 0; i < 1 + nresp; i++) xchk(8'hFF, tag);
    endtask

    task automatic wait_token();
        logic [7:0] got;
        logic       hit;
        exp_q.push_back(8'hFE);
        hit = 1'b0;
        got = 8'hFF;
        for (int i = 0; i < 40 && !hit; i++) begin
            xfer(8'hFF, got);
            if (got !== 8'hFF) hit = 1'b1;
        end
        check("token", {24'd0, got}, {24'd0, exp_q.pop_front()});
    endtask

    // memory model: answers each request 10 clk after it rises, unless it is withdrawn
    initial begin
        rd_ack  = 1'b0;
        rd_data = 8'h00;
        forever begin
            @(negedge clk);
            if (rd_req) begin
                repeat (9) @(negedge clk);
                if (rd_req) begin
                    rd_data = rd_idx[7:0] ^ 8'h5A;
                    rd_ack  = 1'b1;
                    @(negedge clk);
                    rd_ack  = 1'b0;
                end
            end
        end
    end

    initial begin
        #900000;
        $display("FAIL watchdog: run did not complete in time");
        $fatal(1, "timeout");
    end

    initial begin
        n_rst = 1'b0;
        sck   = 1'b0;
        mosi  = 1'b1;
        n_cs  = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_miso", {31'd0, miso}, 32'd1);
        check("rst_oe", {31'd0, miso_oe}, 32'd0);
        check("rst_req", {31'd0, rd_req}, 32'd0);
        check("rst_lba", rd_lba, 32'd0);
        check("rst_idx", {23'd0, rd_idx}, 32'd0);
        n_rst = 1'b1;
        repeat (4) @(negedge clk);
        check("desel_miso", {31'd0, miso}, 32'd1);

        n_cs = 1'b0;
        repeat (8) @(negedge clk);
        check("sel_oe", {31'd0, miso_oe}, 32'd1);

        command(6'd0, 32'd0, 8'h95, 1, {8'h01, 32'd0}, "cmd0");
`ifdef SD_SPI_CRC_EN
        command(6'd0, 32'd0, 8'h01, 1, {8'h09, 32'd0}, "cmd0_badcrc");
        command(6'd0, 32'd0, 8'h95, 1, {8'h01, 32'd0}, "cmd0_goodcrc");
`endif
        command(6'd8, 32'h0000_01AA, cmd_crc(6'd8, 32'h0000_01AA), 5, 40'h01_00_00_01_AA, "cmd8");
        command(6'd17, 32'd5, cmd_crc(6'd17, 32'd5), 1, {8'h05, 32'd0}, "cmd17_idle");
        command(6'd55, 32'd0, cmd_crc(6'd55, 32'd0), 1, {8'h01, 32'd0}, "cmd55");
        command(6'd41, 32'h4000_0000, cmd_crc(6'd41, 32'h4000_0000), 1, {8'h00, 32'd0}, "acmd41");
        command(6'd58, 32'd0, cmd_crc(6'd58, 32'd0), 5, 40'h00_C0_FF_80_00, "cmd58");
        command(6'd13, 32'd0, cmd_crc(6'd13, 32'd0), 1, {8'h04, 32'd0}, "cmd13_unknown");

        command(6'd17, 32'd5, cmd_crc(6'd17, 32'd5), 1, {8'h00, 32'd0}, "cmd17");
        check("rd_lba", rd_lba, 32'd5);
        wait_token();
        dcrc = 16'h0000;
        for (int i = 0; i < 512; i++) begin
            b = 8'(i) ^ 8'h5A;
            dcrc = crc16_upd(dcrc, b);
            exp_q.push_back(b);
            xchk(8'hFF, "data");
        end
`ifndef SD_SPI_CRC_EN
        dcrc = 16'hFFFF;
`endif
        exp_q.push_back(dcrc[15:8]);
        exp_q.push_back(dcrc[7:0]);
        xchk(8'hFF, "crc_hi");
        xchk(8'hFF, "crc_lo");

        command(6'd17, 32'd5, cmd_crc(6'd17, 32'd5), 1, {8'h00, 32'd0}, "cmd17_abort");
        wait_token();
        for (int i = 0; i < 100; i++) begin
            exp_q.push_back(8'(i) ^ 8'h5A);
            xchk(8'hFF, "data_abort");
        end
        found = 1'b0;
        for (int i = 0; i < 10 && !found; i++) begin
            @(negedge clk);
            if (rd_req) found = 1'b1;
        end
        check("prefetch_seen", {31'd0, found}, 32'd1);
        check("prefetch_idx", {23'd0, rd_idx}, 32'd101);
        n_cs = 1'b1;
        repeat (3) @(negedge clk);
        check("abort_req", {31'd0, rd_req}, 32'd0);
        check("abort_oe", {31'd0, miso_oe}, 32'd0);
        check("abort_miso", {31'd0, miso}, 32'd1);
        repeat (10) @(negedge clk);

        n_cs = 1'b0;
        repeat (8) @(negedge clk);
        command(6'd58, 32'd0, cmd_crc(6'd58, 32'd0), 5, 40'h00_C0_FF_80_00, "cmd58_after");
        n_cs = 1'b1;
        repeat (8) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
